fpu_adder_master: RTL and testbench

Initiator-side companion to the single-precision floating-point adder. It accepts one operand pair per job from a host-side stb/ack port, drives the pair into the adder's `input_a`/`input_b` handshakes in order, and collects `output_z`. It then presents the sum on a host-side result port. A watchdog aborts a stalled adder transaction and raises a sticky error. The block sits between a host/sequencer and one adder instance.

---
 rtl/fpu_adder_master.sv | 179 +++++++++++++++++
 tb/tb_fpu_adder_master.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_adder_master.sv
// Initiator for a stb/ack single-precision adder: takes one operand pair per job,
// feeds input_a/input_b in order, collects output_z and hands the sum back to the host.
`timescale 1ns/1ps
module fpu_adder_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      job_a,
    input  logic [31:0]      job_b,
    input  logic             job_stb,
    output logic             job_ack,
    output logic [31:0]      input_a,
    output logic             input_a_stb,
    input  logic             input_a_ack,
    output logic [31:0]      input_b,
    output logic             input_b_stb,
    input  logic             input_b_ack,
    input  logic [31:0]      output_z,
    input  logic             output_z_stb,
    output logic             output_z_ack,
    output logic [31:0]      result,
    output logic             result_stb,
    input  logic             result_ack,
    output logic             busy,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] done_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND_A  = 3'd1;
    localparam logic [2:0] S_SEND_B  = 3'd2;
    localparam logic [2:0] S_WAIT_Z  = 3'd3;
    localparam logic [2:0] S_DELIVER = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    logic [2:0]       r_state;
    logic [15:0]      r_wd;
    logic             r_job_ack;
    logic             r_a_stb;
    logic             r_b_stb;
    logic             r_z_ack;
    logic             r_res_stb;
    logic             r_err;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_res;
    logic [CNT_W-1:0] r_done;

    logic w_job_xfer;
    logic w_a_xfer;
    logic w_b_xfer;
    logic w_z_xfer;
    logic w_res_xfer;
    logic w_waiting;
    logic w_phase_xfer;
    logic w_expire;

    assign w_job_xfer = job_stb & r_job_ack;
    assign w_a_xfer   = r_a_stb & input_a_ack;
    assign w_b_xfer   = r_b_stb & input_b_ack;
    assign w_z_xfer   = output_z_stb & r_z_ack;
    assign w_res_xfer = r_res_stb & result_ack;

    assign w_waiting    = (r_state == S_SEND_A) || (r_state == S_SEND_B) || (r_state == S_WAIT_Z);
    assign w_phase_xfer = ((r_state == S_SEND_A) && w_a_xfer) ||
                          ((r_state == S_SEND_B) && w_b_xfer) ||
                          ((r_state == S_WAIT_Z) && w_z_xfer);
    // r_wd counts cycles already spent in the phase; this edge would make it TIMEOUT.
    assign w_expire = (({1'b0, r_wd} + 17'd1) == 17'(TIMEOUT));

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of its peers, exactly like the flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wd      <= '0;
            r_job_ack <= 1'b0;
            r_a_stb   <= 1'b0;
            r_b_stb   <= 1'b0;
            r_z_ack   <= 1'b0;
            r_res_stb <= 1'b0;
            r_err     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_done    <= '0;
        end else if (w_waiting && !w_phase_xfer && w_expire) begin
            // A transfer on the expiry edge takes the branch below instead.
            r_a_stb <= 1'b0;
            r_b_stb <= 1'b0;
            r_z_ack <= 1'b0;
            r_err   <= 1'b1;
            r_wd    <= '0;
            r_state <= S_ERROR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_job_xfer) begin
                        r_a       <= job_a;
                        r_b       <= job_b;
                        r_job_ack <= 1'b0;
                        r_a_stb   <= 1'b1;
                        r_wd      <= '0;
                        r_state   <= S_SEND_A;
                    end else begin
                        r_job_ack <= 1'b1;
                    end
                end
                S_SEND_A: begin
                    if (w_a_xfer) begin
                        r_a_stb <= 1'b0;
                        r_b_stb <= 1'b1;
                        r_wd    <= '0;
                        r_state <= S_SEND_B;
                    end else begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
                S_SEND_B: begin
                    if (w_b_xfer) begin
                        r_b_stb <= 1'b0;
                        r_z_ack <= 1'b1;
                        r_wd    <= '0;
                        r_state <= S_WAIT_Z;
                    end else begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
                S_WAIT_Z: begin
                    if (w_z_xfer) begin
                        r_res     <= output_z;
                        r_z_ack   <= 1'b0;
                        r_res_stb <= 1'b1;
                        r_wd      <= '0;
                        r_state   <= S_DELIVER;
                    end else begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
                S_DELIVER: begin
                    if (w_res_xfer) begin
                        r_res_stb <= 1'b0;
                        r_done    <= r_done + CNT_W'(1);
                        r_wd      <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    r_job_ack <= 1'b0;
                    if (err_clr) begin
                        r_err   <= 1'b0;
                        r_wd    <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_wd    <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign job_ack      = r_job_ack;
    assign input_a      = r_a;
    assign input_a_stb  = r_a_stb;
    assign input_b      = r_b;
    assign input_b_stb  = r_b_stb;
    assign output_z_ack = r_z_ack;
    assign result       = r_res;
    assign result_stb   = r_res_stb;
    assign busy         = (r_state != S_IDLE);
    assign err          = r_err;
    assign done_count   = r_done;

endmodule

// File: tb/tb_fpu_adder_master.sv
// Bench for fpu_adder_master: stub adder, host driver and a transaction-level
// model of the job protocol checked every cycle, plus literal pins.
`timescale 1ns/1ps
module tb_fpu_adder_master;

    localparam int TMO = 16;
    localparam int CW  = 4;
    localparam int P_IDLE = 0, P_A = 1, P_B = 2, P_Z = 3, P_DEL = 4, P_ERR = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   job_a = '0, job_b = '0;
    logic          job_stb = 1'b0;
    logic          job_ack;
    logic [31:0]   input_a, input_b, result;
    logic          input_a_stb, input_b_stb, output_z_ack, result_stb, busy, err;
    logic          input_a_ack = 1'b0, input_b_ack = 1'b0;
    logic [31:0]   output_z = '0;
    logic          output_z_stb = 1'b0;
    logic          result_ack = 1'b0;
    logic          err_clr = 1'b0;
    logic [CW-1:0] done_count;

    always #5 clk = ~clk;

    fpu_adder_master #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst_n),
        .job_a(job_a), .job_b(job_b), .job_stb(job_stb), .job_ack(job_ack),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
        .result(result), .result_stb(result_stb), .result_ack(result_ack),
        .busy(busy), .err(err), .err_clr(err_clr), .done_count(done_count)
    );

    int checks = 0;
    int errors = 0;

    // model of the job protocol
    int          m_phase = P_IDLE, m_wait = 0, m_idle_edges = 0, m_done = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_res = '0;
    logic [31:0] mq_a[$], mq_b[$];
    logic [31:0] got[$];
    // host side
    logic [31:0] hq_a[$], hq_b[$];
    int          rack_mode = 1;       // 0 random, 1 always, 2 hold off
    // stub adder
    int          b_mode = 0;          // 0 random, 1 never, 2 only on the expiry edge
    int          z_mode = 0;          // 0 normal, 1 never answers
    int          sb_cnt = 0, z_cnt = 0, b_high_cnt = 0;
    logic        s_zpend = 1'b0;
    logic [31:0] s_a = '0, s_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Stub adder arithmetic: a few real IEEE-754 sums, integer add otherwise.
    function automatic logic [31:0] adder_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (a == 32'h40000000 && b == 32'hC0000000) return 32'h00000000;
        if (a == 32'h7F800000 && b == 32'h3F800000) return 32'h7F800000;
        return a + b;
    endfunction

    task automatic compare_outputs();
        check("job_ack", 32'(job_ack), 32'(m_phase == P_IDLE && m_idle_edges >= 1));
        check("input_a_stb", 32'(input_a_stb), 32'(m_phase == P_A));
        check("input_b_stb", 32'(input_b_stb), 32'(m_phase == P_B));
        check("output_z_ack", 32'(output_z_ack), 32'(m_phase == P_Z));
        check("result_stb", 32'(result_stb), 32'(m_phase == P_DEL));
        check("busy", 32'(busy), 32'(m_phase != P_IDLE));
        check("err", 32'(err), 32'(m_err));
        check("done_count", 32'(done_count), 32'(m_done % (1 << CW)));
        if (m_phase == P_A) check("input_a", input_a, mq_a[0]);
        if (m_phase == P_B) check("input_b", input_b, mq_b[0]);
        if (m_phase == P_DEL) check("result", result, m_res);
    endtask

    task automatic stub_clear();
        s_zpend = 1'b0;
        output_z_stb = 1'b0;
        input_a_ack = 1'b0;
        input_b_ack = 1'b0;
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_wait = 0; m_idle_edges = 0; m_done = 0; m_err = 1'b0;
        mq_a.delete(); mq_b.delete(); hq_a.delete(); hq_b.delete();
        job_stb = 1'b0;
    endtask

    // One clock: sample and compare at negedge, advance the model and drive #1 after posedge.
    task automatic cycle();
        logic jx, ax, bx, zx, rx, clr;
        logic [31:0] va, vb, vr;
        @(negedge clk);
        jx = job_stb & job_ack;
        ax = input_a_stb & input_a_ack;
        bx = input_b_stb & input_b_ack;
        zx = output_z_stb & output_z_ack;
        rx = result_stb & result_ack;
        clr = err_clr;
        va = input_a; vb = input_b; vr = result;
        compare_outputs();
        if (input_b_stb) b_high_cnt++;
        @(posedge clk);
        #1;
        // model
        case (m_phase)
            P_IDLE: begin
                if (jx) begin
                    mq_a.push_back(job_a); mq_b.push_back(job_b);
                    m_phase = P_A; m_wait = 0;
                end else if (m_idle_edges < 1000) begin
                    m_idle_edges++;
                end
            end
            P_A, P_B, P_Z: begin
                if ((m_phase == P_A && ax) || (m_phase == P_B && bx) || (m_phase == P_Z && zx)) begin
                    if (m_phase == P_A) m_phase = P_B;
                    else if (m_phase == P_B) m_phase = P_Z;
                    else begin
                        m_res = adder_fn(mq_a[0], mq_b[0]);
                        m_phase = P_DEL;
                    end
                    m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_phase = P_ERR; m_err = 1'b1;
                        void'(mq_a.pop_front()); void'(mq_b.pop_front());
                    end
                end
            end
            P_DEL: begin
                if (rx) begin
                    got.push_back(vr);
                    m_done++;
                    void'(mq_a.pop_front()); void'(mq_b.pop_front());
                    m_phase = P_IDLE; m_idle_edges = 0;
                end
            end
            default: begin
                if (clr) begin
                    m_err = 1'b0; m_phase = P_IDLE; m_idle_edges = 0;
                end
            end
        endcase
        // host
        if (jx) begin
            job_stb = 1'b0;
            void'(hq_a.pop_front()); void'(hq_b.pop_front());
        end
        if (!job_stb && hq_a.size() > 0) begin
            job_a = hq_a[0]; job_b = hq_b[0]; job_stb = 1'b1;
        end
        case (rack_mode)
            0: result_ack = 1'($urandom % 2);
            1: result_ack = 1'b1;
            default: result_ack = 1'b0;
        endcase
        // stub adder
        if (ax) begin s_a = va; sb_cnt = 0; end
        else sb_cnt++;
        if (bx) begin s_b = vb; s_zpend = 1'b1; z_cnt = $urandom_range(0, 4); end
        if (zx) output_z_stb = 1'b0;
        if (s_zpend && !output_z_stb && z_mode == 0) begin
            if (z_cnt == 0) begin
                output_z = adder_fn(s_a, s_b); output_z_stb = 1'b1; s_zpend = 1'b0;
            end else begin
                z_cnt--;
            end
        end
        input_a_ack = (($urandom % 4) != 0);
        case (b_mode)
            0: input_b_ack = (($urandom % 4) != 0);
            1: input_b_ack = 1'b0;
            default: input_b_ack = (sb_cnt == TMO - 1);
        endcase
    endtask

    task automatic run_idle(input int budget, input string name);
        int n = 0;
        do begin
            cycle(); n++;
        end while (!(hq_a.size() == 0 && !job_stb && m_phase == P_IDLE && m_idle_edges >= 1) && n < budget);
        check({"drain ", name}, 32'(m_phase == P_IDLE && hq_a.size() == 0), 32'd1);
    endtask

    task automatic run_phase(input int p, input int budget, input string name);
        int n = 0;
        do begin
            cycle(); n++;
        end while (m_phase != p && n < budget);
        check({"reach ", name}, 32'(m_phase), 32'(p));
    endtask

    task automatic push_job(input logic [31:0] a, input logic [31:0] b);
        hq_a.push_back(a); hq_b.push_back(b);
    endtask

    initial begin
        logic [31:0] r0;
        int stable;
        // reset values, asserted from time 0
        #1;
        check("rst job_ack", 32'(job_ack), 32'd0);
        check("rst input_a_stb", 32'(input_a_stb), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst done_count", 32'(done_count), 32'd0);
        check("rst result", result, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();
        check("job_ack after release", 32'(job_ack), 32'd1);

        // single job through the adder
        rack_mode = 1;
        push_job(32'h3F800000, 32'h40000000);
        run_idle(80, "job1");
        check("job1 result", got[0], 32'h40400000);
        check("job1 done_count", 32'(done_count), 32'd1);
        check("job1 busy", 32'(busy), 32'd0);

        // three back-to-back jobs
        push_job(32'h3F800000, 32'h3F800000);
        push_job(32'h40000000, 32'hC0000000);
        push_job(32'h7F800000, 32'h3F800000);
        run_idle(200, "three");
        check("b2b result 0", got[1], 32'h40000000);
        check("b2b result 1", got[2], 32'h00000000);
        check("b2b result 2", got[3], 32'h7F800000);

        // counter wrap at CNT_W=4
        rack_mode = 0;
        for (int i = 0; i < 11; i++) push_job($urandom, $urandom);
        run_idle(800, "to15");
        check("done_count 15", 32'(done_count), 32'd15);
        push_job($urandom, $urandom);
        run_idle(100, "job16");
        check("done_count wrap", 32'(done_count), 32'd0);
        push_job($urandom, $urandom);
        run_idle(100, "job17");
        check("done_count 17", 32'(done_count), 32'd1);

        for (int i = 0; i < 30; i++) push_job($urandom, $urandom);
        run_idle(2000, "random");

        // host stalls the result for 20 cycles
        rack_mode = 2;
        push_job(32'h12345678, 32'h01010101);
        run_phase(P_DEL, 100, "deliver");
        r0 = result;
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (result === r0 && result_stb === 1'b1 && job_ack === 1'b0 && err === 1'b0) stable++;
        end
        check("stall stable cycles", 32'(stable), 32'd20);
        check("stall result value", r0, 32'h13355779);
        rack_mode = 1;
        result_ack = 1'b1;
        cycle();
        check("stall released stb", 32'(result_stb), 32'd0);
        check("stall released busy", 32'(busy), 32'd0);
        run_idle(10, "after stall");

        // adder never accepts B
        b_mode = 1;
        push_job(32'h00000001, 32'h00000002);
        run_phase(P_B, 100, "send_b");
        b_high_cnt = 0;
        run_phase(P_ERR, 40, "error");
        check("timeout b_stb cycles", 32'(b_high_cnt), 32'(TMO));
        check("timeout b_stb low", 32'(input_b_stb), 32'd0);
        check("timeout err", 32'(err), 32'd1);
        check("timeout job_ack", 32'(job_ack), 32'd0);
        cycle(); cycle(); cycle();
        check("err sticky", 32'(err), 32'd1);
        stub_clear();
        b_mode = 0;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("err cleared", 32'(err), 32'd0);
        check("job_ack after clr edge", 32'(job_ack), 32'd0);
        cycle();
        check("job_ack one edge later", 32'(job_ack), 32'd1);

        // B accepted exactly on the expiry edge
        b_mode = 2;
        push_job(32'h3F800000, 32'h3F800000);
        run_phase(P_B, 100, "send_b 2");
        b_high_cnt = 0;
        run_phase(P_Z, 40, "wait_z");
        check("late ack b_stb cycles", 32'(b_high_cnt), 32'(TMO));
        check("late ack no err", 32'(err), 32'd0);
        b_mode = 0;
        run_idle(100, "late ack");
        check("late ack result", got[got.size()-1], 32'h40000000);

        // reset in the middle of WAIT_Z
        z_mode = 1;
        push_job(32'h3F800000, 32'h40000000);
        run_phase(P_Z, 100, "wait_z 2");
        cycle(); cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst job_ack", 32'(job_ack), 32'd0);
        check("midrst stbs", {29'd0, input_a_stb, input_b_stb, output_z_ack}, 32'd0);
        check("midrst result_stb", 32'(result_stb), 32'd0);
        check("midrst operands", input_a | input_b, 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst busy err", {30'd0, busy, err}, 32'd0);
        check("midrst done_count", 32'(done_count), 32'd0);
        model_reset();
        stub_clear();
        z_mode = 0;
        @(posedge clk);
        #1;
        check("midrst held result_stb", 32'(result_stb), 32'd0);
        rst_n = 1'b1;
        push_job(32'h3F800000, 32'h3F800000);
        run_idle(100, "after reset");
        check("after reset done_count", 32'(done_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

endmodule
